// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, HD44780 command constants and helpers for the LCD bus arbiter
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY      = 8'h06;
    localparam logic [7:0] CMD_DDRAM_ROW1 = 8'h80;
    localparam logic [7:0] CMD_DDRAM_ROW2 = 8'hC0;
    localparam logic [7:0] CMD_CGRAM      = 8'h40;

    // Clear and home are the only commands needing the long post-command wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// rtl/lcd_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module lcd_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate back toward ptr so the one nearest ptr wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - round-robin, frame-locked sharing of one HD44780 write bus
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int SETUP_CYC    = 1,
    parameter int E_HIGH_CYC   = 4,
    parameter int HOLD_CYC     = 1,
    parameter int CMD_WAIT_CYC = 2,
    parameter int CLR_WAIT_CYC = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         last,
    input  logic [N_REQ-1:0]         rs_in,
    input  logic [8*N_REQ-1:0]       data_in,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     locked,
    output logic                     lcd_rs,
    output logic                     lcd_rw,
    output logic                     lcd_e,
    output logic [7:0]               lcd_data
);

    localparam int IW   = $clog2(N_REQ);
    localparam int MAXC = max_int(max_int(max_int(SETUP_CYC, E_HIGH_CYC), max_int(HOLD_CYC, CMD_WAIT_CYC)),
                                  CLR_WAIT_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    lcd_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] rr_ptr;
    logic          last_q;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          take;
    logic [IW-1:0] take_id;
    logic          take_rs;
    logic          take_last;
    logic [7:0]    take_data;
    logic          owner_req;
    logic          byte_done;
    logic [CW-1:0] wait_len;

    assign lcd_rw = 1'b0;

    lcd_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Post-byte idle length depends on the byte currently on the bus.
    assign wait_len = is_slow_cmd(lcd_rs, lcd_data) ? CW'(CLR_WAIT_CYC) : CW'(CMD_WAIT_CYC);

    // Mux the owner's request and the winning requester's byte.
    always_comb begin
        owner_req = 1'b0;
        take_rs   = 1'b0;
        take_last = 1'b0;
        take_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == grant_id) begin
                owner_req = req[i];
            end
            if (IW'(i) == take_id) begin
                take_rs   = rs_in[i];
                take_last = last[i];
                take_data = data_in[8*i +: 8];
            end
        end
    end

    // Next-state and phase counter; a locked bus only listens to its owner.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        take_id = grant_id;
        unique case (state)
            S_IDLE: begin
                if (locked) begin
                    take = owner_req;
                end else begin
                    take    = pick_valid;
                    take_id = pick_idx;
                end
                if (take) begin
                    state_n = S_SETUP;
                    cnt_n   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_n = S_EHIGH;
                    cnt_n   = CW'(E_HIGH_CYC - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EHIGH: begin
                if (cnt == '0) begin
                    state_n = S_HOLD;
                    cnt_n   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    if (wait_len == '0) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = wait_len - CW'(1);
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign byte_done = (state != S_IDLE) && (state_n == S_IDLE);

    // State, latched byte, lock/pointer bookkeeping and registered bus strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            last_q   <= 1'b0;
            ack      <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lcd_e <= (state_n == S_EHIGH);
            ack   <= '0;
            if (take) begin
                ack[take_id] <= 1'b1;
                grant_id     <= take_id;
                lcd_rs       <= take_rs;
                lcd_data     <= take_data;
                last_q       <= take_last;
                // Final byte of a multi-byte frame keeps the lock until it has been sent.
                locked       <= locked | ~take_last;
                rr_ptr       <= (take_id == IW'(N_REQ - 1)) ? '0 : take_id + IW'(1);
            end else if (byte_done && last_q) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - randomized self-checking bench with a timeline reference model
module tb_lcd_bus_arbiter;

    localparam int N        = 4;
    localparam int SETUP    = 1;
    localparam int EHIGH    = 4;
    localparam int HOLD     = 1;
    localparam int CMD_WAIT = 2;
    localparam int CLR_WAIT = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_r = '0;
    logic [N-1:0]   last_r = '0;
    logic [N-1:0]   rs_r = '0;
    logic [8*N-1:0] data_r = '0;
    logic [N-1:0]   ack;
    logic [1:0]     grant_id;
    logic           locked;
    logic           lcd_rs;
    logic           lcd_rw;
    logic           lcd_e;
    logic [7:0]     lcd_data;

    lcd_bus_arbiter #(
        .N_REQ        (N),
        .SETUP_CYC    (SETUP),
        .E_HIGH_CYC   (EHIGH),
        .HOLD_CYC     (HOLD),
        .CMD_WAIT_CYC (CMD_WAIT),
        .CLR_WAIT_CYC (CLR_WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req_r),
        .last     (last_r),
        .rs_in    (rs_r),
        .data_in  (data_r),
        .ack      (ack),
        .grant_id (grant_id),
        .locked   (locked),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       last;
        int         gap;
    } byte_t;

    byte_t q[N][$];
    int    gapc[N];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bus timeline in edge numbers.
    int         edge_n = 0;
    int         next_free = 0;
    int         m_ptr = 0;
    int         m_owner = 0;
    bit         m_locked = 0;
    bit         m_act = 0;
    int         m_acc = 0;
    int         m_p = 0;
    bit         m_last = 0;
    logic [N-1:0] e_ack = '0;
    logic       e_e = 0;
    logic       e_rs = 0;
    logic [7:0] e_data = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    function automatic int byte_period(input logic rs, input logic [7:0] data);
        int w;
        w = (!rs && (data == 8'h01 || data == 8'h02)) ? CLR_WAIT : CMD_WAIT;
        return 1 + SETUP + EHIGH + HOLD + w;
    endfunction

    task automatic model_edge();
        int win;
        edge_n++;
        e_ack = '0;
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_locked = 0; m_act = 0; m_last = 0;
            e_e = 0; e_rs = 0; e_data = 0;
            next_free = edge_n + 1;
            return;
        end
        if (m_act && edge_n == m_acc + m_p - 1 && m_last) m_locked = 0;
        if (edge_n >= next_free) begin
            win = -1;
            if (m_locked) begin
                if (req_r[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (win < 0 && req_r[j]) win = j;
                end
            end
            if (win >= 0) begin
                e_ack[win] = 1'b1;
                m_owner  = win;
                e_rs     = rs_r[win];
                e_data   = data_r[8*win +: 8];
                m_last   = last_r[win];
                m_locked = m_locked || !m_last;
                m_ptr    = (win + 1) % N;
                m_act    = 1;
                m_acc    = edge_n;
                m_p      = byte_period(e_rs, e_data);
                next_free = edge_n + m_p;
            end
        end
        e_e = m_act && (edge_n >= m_acc + SETUP) && (edge_n < m_acc + SETUP + EHIGH);
    endtask

    task automatic check_outputs();
        check_eq("ack", 32'(ack), 32'(e_ack));
        check_eq("lcd_e", 32'(lcd_e), 32'(e_e));
        check_eq("locked", 32'(locked), 32'(m_locked));
        check_eq("grant_id", 32'(grant_id), 32'(m_owner));
        check_eq("lcd_rs", 32'(lcd_rs), 32'(e_rs));
        check_eq("lcd_data", 32'(lcd_data), 32'(e_data));
        check_eq("lcd_rw", 32'(lcd_rw), 32'd0);
    endtask

    task automatic drive_update();
        for (int i = 0; i < N; i++) begin
            if (req_r[i] && ack[i]) begin
                void'(q[i].pop_front());
                req_r[i] = 1'b0;
                if (q[i].size() > 0) gapc[i] = q[i][0].gap;
            end
            if (!req_r[i] && q[i].size() > 0) begin
                if (gapc[i] > 0) begin
                    gapc[i]--;
                end else begin
                    req_r[i]          = 1'b1;
                    rs_r[i]           = q[i][0].rs;
                    last_r[i]         = q[i][0].last;
                    data_r[8*i +: 8]  = q[i][0].data;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        drive_update();
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic push_byte(input int i, input logic rs, input logic [7:0] data,
                             input logic lst, input int gap);
        byte_t t;
        t.rs = rs; t.data = data; t.last = lst; t.gap = gap;
        if (q[i].size() == 0) gapc[i] = gap;
        q[i].push_back(t);
    endtask

    task automatic push_random_frame(input int i);
        int nb;
        int g;
        logic [7:0] d;
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
            case ($urandom_range(0, 4))
                0: d = 8'h01;
                1: d = 8'h02;
                2: d = 8'h38;
                default: d = 8'($urandom);
            endcase
            if (b == 0) g = $urandom_range(0, 3);
            else g = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 60) : $urandom_range(0, 2);
            push_byte(i, 1'($urandom_range(0, 1)), d, b == nb - 1, g);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            gapc[i] = 0;
        end
        req_r = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        for (int i = 0; i < N; i++) gapc[i] = 0;
        apply_reset();
        run(4);

        push_byte(1, 1'b1, 8'h41, 1'b1, 0);
        run(15);

        push_byte(0, 1'b0, 8'h01, 1'b1, 0);
        run(35);
        push_byte(0, 1'b1, 8'h01, 1'b1, 0);
        run(15);
        push_byte(2, 1'b0, 8'h02, 1'b1, 0);
        run(35);

        push_byte(0, 1'b1, 8'h10, 1'b0, 0);
        push_byte(0, 1'b1, 8'h11, 1'b0, 0);
        push_byte(0, 1'b1, 8'h12, 1'b1, 0);
        push_byte(2, 1'b1, 8'h20, 1'b1, 0);
        run(60);

        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_byte(i, 1'b1, 8'(8'h30 + 4*r + i), 1'b1, 0);
        run(90);

        push_byte(0, 1'b0, 8'h80, 1'b0, 0);
        push_byte(0, 1'b1, 8'h55, 1'b1, 50);
        push_byte(1, 1'b1, 8'h66, 1'b1, 3);
        push_byte(3, 1'b1, 8'h77, 1'b1, 3);
        run(110);

        push_byte(3, 1'b1, 8'h99, 1'b0, 0);
        push_byte(3, 1'b1, 8'h9A, 1'b1, 0);
        guard = 0;
        while (!e_e && guard < 30) begin
            step();
            guard++;
        end
        check_eq("reach_ehigh", 32'(e_e), 32'd1);
        step();
        apply_reset();
        push_byte(3, 1'b1, 8'hA3, 1'b1, 0);
        push_byte(0, 1'b1, 8'hA0, 1'b1, 0);
        run(40);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 1499) == 0) apply_reset();
            for (int i = 0; i < N; i++)
                if (q[i].size() == 0 && $urandom_range(0, 7) == 0) push_random_frame(i);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
